// File: rtl/traffic_monitor_if.sv
// Lamp sample bus between the traffic-light sequencer and its monitor.
// The sequencer drives the master side; the monitor observes through the slave side.
interface traffic_monitor_if;
   logic en;
   logic red;
   logic amber;
   logic green;

   modport master (output en, red, amber, green);
   modport slave  (input  en, red, amber, green);
endinterface

// File: rtl/traffic_monitor.sv
// Checks the UK lamp sequence R -> R+A -> G -> A -> R and its dwell limits, counts completed
// light cycles, and latches a sticky error with the offending sample.
module traffic_monitor #(
   parameter int unsigned MAX_DWELL = 1,
   parameter int unsigned DWELL_W   = 8,
   parameter int unsigned CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   traffic_monitor_if.slave         lamps,
   input  logic                     clear,
   output logic                     locked,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic [2:0]               err_lights,
   output logic [CNT_W-1:0]         cycle_count
);

   typedef enum logic [1:0] {StSync, StTrack, StError} state_e;

   state_e               state_q, state_d;
   logic [2:0]           prev_q, prev_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [1:0]           code_q, code_d;
   logic [2:0]           lights_q, lights_d;
   logic [CNT_W-1:0]     count_q, count_d;

   logic [2:0] sample;
   logic       legal;
   logic [2:0] succ;

   assign sample = {lamps.red, lamps.amber, lamps.green};

   always_comb begin
      legal = 1'b0;
      succ  = 3'b000;
      unique case (sample)
         3'b100, 3'b110, 3'b001, 3'b010: legal = 1'b1;
         default: legal = 1'b0;
      endcase
      unique case (prev_q)
         3'b100:  succ = 3'b110;
         3'b110:  succ = 3'b001;
         3'b001:  succ = 3'b010;
         3'b010:  succ = 3'b100;
         default: succ = 3'b000;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      dwell_d  = dwell_q;
      code_d   = code_q;
      lights_d = lights_q;
      count_d  = count_q;
      // clear wins over a same-cycle sample, which is simply dropped
      if (clear) begin
         state_d  = StSync;
         code_d   = 2'b00;
         lights_d = 3'b000;
         dwell_d  = '0;
      end else if (lamps.en) begin
         unique case (state_q)
            StSync: begin
               if (legal) begin
                  state_d = StTrack;
                  prev_d  = sample;
                  dwell_d = DWELL_W'(1);
               end else begin
                  state_d  = StError;
                  code_d   = 2'b01;
                  lights_d = sample;
               end
            end
            StTrack: begin
               if (!legal) begin
                  state_d  = StError;
                  code_d   = 2'b01;
                  lights_d = sample;
               end else if (sample == prev_q) begin
                  if (dwell_q == DWELL_W'(MAX_DWELL)) begin
                     state_d  = StError;
                     code_d   = 2'b11;
                     lights_d = sample;
                  end else begin
                     dwell_d = dwell_q + DWELL_W'(1);
                  end
               end else if (sample != succ) begin
                  state_d  = StError;
                  code_d   = 2'b10;
                  lights_d = sample;
               end else begin
                  prev_d  = sample;
                  dwell_d = DWELL_W'(1);
                  if (prev_q == 3'b010 && count_q != '1) count_d = count_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StSync;
         prev_q   <= 3'b000;
         dwell_q  <= '0;
         code_q   <= 2'b00;
         lights_q <= 3'b000;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         dwell_q  <= dwell_d;
         code_q   <= code_d;
         lights_q <= lights_d;
         count_q  <= count_d;
      end
   end

   assign locked      = (state_q == StTrack);
   assign err         = (state_q == StError);
   assign err_code    = code_q;
   assign err_lights  = lights_q;
   assign cycle_count = count_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Bench for traffic_monitor: two instances (MAX_DWELL 1 and 3) share one lamp bus and are
// compared against a sequence-table reference model under directed and random stimulus.
module tb_traffic_monitor;
   logic clk;
   logic rst_n;
   logic clear;
   traffic_monitor_if bus ();

   logic [1:0]       locked_w;
   logic [1:0]       err_w;
   logic [1:0][1:0]  code_w;
   logic [1:0][2:0]  lights_w;
   logic [1:0][7:0]  cnt_w;

   traffic_monitor #(.MAX_DWELL(1), .DWELL_W(8), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .lamps(bus.slave), .clear(clear),
      .locked(locked_w[0]), .err(err_w[0]), .err_code(code_w[0]),
      .err_lights(lights_w[0]), .cycle_count(cnt_w[0])
   );

   traffic_monitor #(.MAX_DWELL(3), .DWELL_W(8), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .lamps(bus.slave), .clear(clear),
      .locked(locked_w[1]), .err(err_w[1]), .err_code(code_w[1]),
      .err_lights(lights_w[1]), .cycle_count(cnt_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2:0] seq [4] = '{3'b100, 3'b110, 3'b001, 3'b010};
   int         max_dw [2] = '{1, 3};

   // Reference model: 0 = sync, 1 = tracking, 2 = error
   int         m_mode [2];
   logic [2:0] m_prev [2];
   int         m_dwell [2];
   int         m_code [2];
   logic [2:0] m_lights [2];
   int         m_cycles [2];

   function automatic int pos_of(logic [2:0] s);
      for (int i = 0; i < 4; i++) if (seq[i] == s) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_prev[k] = 3'b000; m_dwell[k] = 0;
         m_code[k] = 0; m_lights[k] = 3'b000; m_cycles[k] = 0;
      end
   endtask

   task automatic model_fault(input int k, input int code, input logic [2:0] s);
      m_mode[k] = 2; m_code[k] = code; m_lights[k] = s;
   endtask

   task automatic model_step(input logic e, input logic [2:0] s, input logic c);
      for (int k = 0; k < 2; k++) begin
         if (c) begin
            m_mode[k] = 0; m_code[k] = 0; m_lights[k] = 3'b000; m_dwell[k] = 0;
         end else if (e && m_mode[k] == 0) begin
            if (pos_of(s) < 0) model_fault(k, 1, s);
            else begin m_mode[k] = 1; m_prev[k] = s; m_dwell[k] = 1; end
         end else if (e && m_mode[k] == 1) begin
            if (pos_of(s) < 0) model_fault(k, 1, s);
            else if (s == m_prev[k]) begin
               if (m_dwell[k] >= max_dw[k]) model_fault(k, 3, s);
               else m_dwell[k]++;
            end else if (pos_of(s) != (pos_of(m_prev[k]) + 1) % 4) model_fault(k, 2, s);
            else begin
               if (m_prev[k] == 3'b010 && s == 3'b100 && m_cycles[k] < 255) m_cycles[k]++;
               m_prev[k] = s; m_dwell[k] = 1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.d%0d.locked", tag, k), 32'(locked_w[k]), 32'(m_mode[k] == 1));
         chk($sformatf("%s.d%0d.err", tag, k), 32'(err_w[k]), 32'(m_mode[k] == 2));
         chk($sformatf("%s.d%0d.code", tag, k), 32'(code_w[k]), 32'(m_code[k]));
         chk($sformatf("%s.d%0d.lights", tag, k), 32'(lights_w[k]), 32'(m_lights[k]));
         chk($sformatf("%s.d%0d.cycles", tag, k), 32'(cnt_w[k]), 32'(m_cycles[k]));
      end
   endtask

   task automatic step(input string tag, input logic e, input logic [2:0] s, input logic c);
      bus.en = e;
      {bus.red, bus.amber, bus.green} = s;
      clear = c;
      @(posedge clk);
      #1;
      model_step(e, s, c);
      check_all(tag);
   endtask

   initial begin
      int pos;
      logic [2:0] s;
      logic e, c;
      rst_n = 1'b0; clear = 1'b0;
      bus.en = 1'b0; bus.red = 1'b0; bus.amber = 1'b0; bus.green = 1'b0;
      model_reset();
      #2;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Three full legal cycles
      for (int i = 0; i < 13; i++) step("legal", 1'b1, seq[i % 4], 1'b0);
      chk("cycles_after_3", 32'(cnt_w[0]), 32'd3);
      chk("locked_after_3", 32'(locked_w[1]), 32'd1);

      // Illegal encoding, then samples that must be ignored
      step("illegal", 1'b1, 3'b101, 1'b0);
      chk("code01", 32'(code_w[0]), 32'd1);
      chk("lights101", 32'(lights_w[1]), 32'h5);
      step("ignored1", 1'b1, 3'b100, 1'b0);
      step("ignored2", 1'b1, 3'b110, 1'b0);

      // clear with a same-cycle sample, then relock
      step("clear", 1'b1, 3'b100, 1'b1);
      chk("clear_unlocked", 32'(locked_w[0]), 32'd0);
      step("relock", 1'b1, 3'b100, 1'b0);
      chk("cycles_kept", 32'(cnt_w[1]), 32'd3);

      // Bad transition R+A -> A
      step("bt1", 1'b1, 3'b110, 1'b0);
      step("bt2", 1'b1, 3'b010, 1'b0);
      chk("code10", 32'(code_w[0]), 32'd2);

      // Dwell: dut0 trips on the second 100; dut1 tolerates three then moves on
      step("dw_clr", 1'b1, 3'b000, 1'b1);
      for (int i = 0; i < 3; i++) step("dw_a", 1'b1, 3'b100, 1'b0);
      step("dw_b", 1'b1, 3'b110, 1'b0);
      chk("dwell1_code11", 32'(code_w[0]), 32'd3);
      chk("dwell3_ok", 32'(err_w[1]), 32'd0);
      step("dw_clr2", 1'b1, 3'b000, 1'b1);
      for (int i = 0; i < 4; i++) step("dw_c", 1'b1, 3'b100, 1'b0);
      chk("dwell3_code11", 32'(code_w[1]), 32'd3);

      // en low holds everything regardless of lamp activity
      step("en_clr", 1'b1, 3'b000, 1'b1);
      step("en_a", 1'b1, 3'b100, 1'b0);
      for (int i = 0; i < 5; i++) step("en_off", 1'b0, 3'($urandom_range(7)), 1'b0);
      step("en_b", 1'b1, 3'b110, 1'b0);

      // Random traffic: mostly legal progress, some holds, glitches, clears and stalls
      pos = 1;
      for (int i = 0; i < 200; i++) begin
         int r;
         r = $urandom_range(99);
         c = (r < 4);
         e = ($urandom_range(9) != 0);
         if (r < 70) begin pos = (pos + 1) % 4; s = seq[pos]; end
         else if (r < 85) s = seq[pos];
         else s = 3'($urandom_range(7));
         step("rand", e, s, c);
      end

      // Saturation of the cycle counter
      step("sat_clr", 1'b1, 3'b000, 1'b1);
      for (int i = 0; i < 260 * 4 + 1; i++) step("sat", 1'b1, seq[i % 4], 1'b0);
      chk("sat255_d0", 32'(cnt_w[0]), 32'd255);
      chk("sat255_d1", 32'(cnt_w[1]), 32'd255);

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_cnt0", 32'(cnt_w[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step("post_rst", 1'b1, seq[i % 4], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
